ex_stage: RTL and testbench

//  Execute stage: consumes decoded ops from the ID/EX register (aluop, alusel, two 32b operands, dest GPR, write flag).

---
 rtl/ex_stage_pkg.sv | 38 +++
 rtl/ex_stage_div_iter.sv | 119 +++++++++++
 rtl/ex_stage.sv | 118 +++++++++++
 tb/tb_ex_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class and divider-state definitions for the execute stage.
// Also holds the helper that recognises divide ops.
package ex_stage_pkg;

   localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
   localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
   localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [2:0] {
      EXE_RES_NOP   = 3'b000,
      EXE_RES_LOGIC = 3'b001,
      EXE_RES_SHIFT = 3'b010,
      EXE_RES_ARITH = 3'b100
   } alusel_e;

   typedef enum logic [1:0] {
      DivIdle = 2'b00,
      DivBusy = 2'b01,
      DivZero = 2'b10,
      DivDone = 2'b11
   } div_state_e;

   function automatic logic is_div_op(input logic [7:0] aluop);
      return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one shift-subtract step per cycle on magnitudes,
// sign correction applied on the way out.
module ex_stage_div_iter
   import ex_stage_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] DIV0_LO = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sign_op,
   input  logic              annul,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   div_state_e        state_r;
   logic [CNT_W-1:0]  count_r;
   logic [DATA_W-1:0] quo_r;
   logic [DATA_W-1:0] rem_r;
   logic [DATA_W-1:0] dvsr_r;
   logic              neg_q_r;
   logic              neg_r_r;
   logic [DATA_W:0]   trial_s;
   logic [DATA_W-1:0] rem_nxt_s;
   logic              q_bit_s;
   logic              op1_neg_s;
   logic              op2_neg_s;

   assign op1_neg_s = sign_op & op1[DATA_W-1];
   assign op2_neg_s = sign_op & op2[DATA_W-1];

   // One restoring step: shift next dividend bit into the partial remainder and try to subtract.
   always_comb begin
      trial_s = {rem_r, quo_r[DATA_W-1]};
      if (trial_s >= {1'b0, dvsr_r}) begin
         q_bit_s   = 1'b1;
         rem_nxt_s = DATA_W'(trial_s - {1'b0, dvsr_r});
      end else begin
         q_bit_s   = 1'b0;
         rem_nxt_s = trial_s[DATA_W-1:0];
      end
   end

   // Divider FSM and datapath registers; divide-by-zero preloads the final LO/HI directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= DivIdle;
         count_r <= '0;
         quo_r   <= '0;
         rem_r   <= '0;
         dvsr_r  <= '0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else if (annul) begin
         state_r <= DivIdle;
         count_r <= '0;
      end else begin
         case (state_r)
            DivIdle: begin
               if (start) begin
                  count_r <= '0;
                  if (op2 == '0) begin
                     state_r <= DivZero;
                     quo_r   <= DIV0_LO;
                     rem_r   <= op1;
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                  end else begin
                     state_r <= DivBusy;
                     quo_r   <= op1_neg_s ? -op1 : op1;
                     dvsr_r  <= op2_neg_s ? -op2 : op2;
                     rem_r   <= '0;
                     neg_q_r <= op1_neg_s ^ op2_neg_s;
                     neg_r_r <= op1_neg_s;
                  end
               end
            end
            DivBusy: begin
               quo_r   <= {quo_r[DATA_W-2:0], q_bit_s};
               rem_r   <= rem_nxt_s;
               count_r <= count_r + 1'b1;
               if (count_r == CNT_LAST) begin
                  state_r <= DivDone;
               end
            end
            DivZero: state_r <= DivDone;
            DivDone: state_r <= DivIdle;
            default: state_r <= DivIdle;
         endcase
      end
   end

   // Sign-corrected results; overflow (min / -1) negates back to min, which is the wanted answer.
   always_comb begin
      if (neg_q_r) begin
         quotient = -quo_r;
      end else begin
         quotient = quo_r;
      end
      if (neg_r_r) begin
         remainder = -rem_r;
      end else begin
         remainder = rem_r;
      end
   end

   assign busy = (state_r == DivBusy) || (state_r == DivZero);
   assign done = (state_r == DivDone);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith results plus an iterative divider
// that holds the pipeline through stall_req_o until HI/LO are ready.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic              annul_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              whilo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              stall_req_o
);

   localparam int SH_W = $clog2(DATA_W);

   logic              div_start_s;
   logic              div_busy_s;
   logic              div_done_s;
   logic [DATA_W-1:0] div_quo_s;
   logic [DATA_W-1:0] div_rem_s;
   logic [DATA_W-1:0] alu_res_s;
   logic [SH_W-1:0]   shamt_s;

   assign div_start_s = is_div_op(aluop_i);
   assign shamt_s     = reg1_i[SH_W-1:0];

   ex_stage_div_iter #(
      .DATA_W  (DATA_W),
      .DIV0_LO (DIV0_LO)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .sign_op   (aluop_i == EXE_DIV_OP),
      .annul     (annul_i),
      .op1       (reg1_i),
      .op2       (reg2_i),
      .busy      (div_busy_s),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Single-cycle result mux by result class, then by sub-op.
   always_comb begin
      alu_res_s = '0;
      case (alusel_i)
         EXE_RES_LOGIC: begin
            case (aluop_i)
               EXE_OR_OP:  alu_res_s = reg1_i | reg2_i;
               EXE_AND_OP: alu_res_s = reg1_i & reg2_i;
               EXE_XOR_OP: alu_res_s = reg1_i ^ reg2_i;
               EXE_NOR_OP: alu_res_s = ~(reg1_i | reg2_i);
               default:    alu_res_s = '0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: alu_res_s = reg2_i << shamt_s;
               EXE_SRL_OP: alu_res_s = reg2_i >> shamt_s;
               EXE_SRA_OP: alu_res_s = $signed(reg2_i) >>> shamt_s;
               default:    alu_res_s = '0;
            endcase
         end
         EXE_RES_ARITH: begin
            case (aluop_i)
               EXE_ADDU_OP: alu_res_s = reg1_i + reg2_i;
               EXE_SUBU_OP: alu_res_s = reg1_i - reg2_i;
               EXE_SLT_OP:  alu_res_s = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
               EXE_SLTU_OP: alu_res_s = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
               default:     alu_res_s = '0;
            endcase
         end
         default: alu_res_s = '0;
      endcase
   end

   // Output drive; a divide op seen in IDLE stalls in that same cycle, annul kills stall and HI/LO write.
   always_comb begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
      stall_req_o = 1'b0;
      if (!rst) begin
         wd_o = '0;
      end else begin
         wd_o        = wd_i;
         wreg_o      = wreg_i;
         wdata_o     = alu_res_s;
         whilo_o     = div_done_s & ~annul_i;
         stall_req_o = ~annul_i & (div_busy_s | (div_start_s & ~div_done_s));
         if (whilo_o) begin
            hi_o = div_rem_s;
            lo_o = div_quo_s;
         end else begin
            hi_o = '0;
            lo_o = '0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: ALU ops, divides, divide-by-zero, annul and mid-division reset.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [31:0] reg1, reg2;
   logic [4:0]  wd;
   logic        wreg, annul;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stall_req_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   typedef struct {
      logic [31:0] wdata;
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk (clk), .rst (rst), .aluop_i (aluop), .alusel_i (alusel),
      .reg1_i (reg1), .reg2_i (reg2), .wd_i (wd), .wreg_i (wreg), .annul_i (annul),
      .wd_o (wd_o), .wreg_o (wreg_o), .wdata_o (wdata_o), .whilo_o (whilo_o),
      .hi_o (hi_o), .lo_o (lo_o), .stall_req_o (stall_req_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
      end
   endtask

   task automatic run_alu(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
      exp_t e;
      @(posedge clk); #1;
      aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = 5'd9; wreg = 1'b1;
      e.wdata = expv; e.lo = 32'h0; e.hi = 32'h0;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check_val({tag, "_wdata"}, wdata_o, e.wdata);
      check_val({tag, "_stall"}, {31'h0, stall_req_o}, 32'h0);
      check_val({tag, "_whilo"}, {31'h0, whilo_o}, 32'h0);
   endtask

   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_stall, input string tag);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      aluop = op; alusel = EXE_RES_NOP; reg1 = a; reg2 = b; wd = 5'd0; wreg = 1'b0;
      e.wdata = 32'h0; e.lo = exp_lo; e.hi = exp_hi;
      exp_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (stall_req_o === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check_val({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
      check_val({tag, "_whilo"}, {31'h0, whilo_o}, 32'h1);
      e = exp_q.pop_front();
      check_val({tag, "_lo"}, lo_o, e.lo);
      check_val({tag, "_hi"}, hi_o, e.hi);
      check_val({tag, "_wdata"}, wdata_o, e.wdata);
      @(posedge clk); #1;
      aluop = EXE_NOP_OP; reg1 = 32'h0; reg2 = 32'h0;
      @(negedge clk);
      check_val({tag, "_after_whilo"}, {31'h0, whilo_o}, 32'h0);
      check_val({tag, "_after_stall"}, {31'h0, stall_req_o}, 32'h0);
   endtask

   initial begin
      logic seen;
      rst = 1'b0; annul = 1'b0;
      aluop = EXE_OR_OP; alusel = EXE_RES_LOGIC; reg1 = 32'h1100; reg2 = 32'h0011;
      wd = 5'd3; wreg = 1'b1;
      #12;
      check_val("reset_ctrl", {24'h0, wd_o, wreg_o, whilo_o, stall_req_o}, 32'h0);
      check_val("reset_wdata", wdata_o, 32'h0);
      check_val("reset_hilo", hi_o | lo_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      run_alu(EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 32'h0000_1111, "ori");
      check_val("ori_wd", {27'h0, wd_o}, 32'd9);
      check_val("ori_wreg", {31'h0, wreg_o}, 32'h1);
      run_alu(EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, "and");
      run_alu(EXE_XOR_OP,  EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor");
      run_alu(EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00F0_0001, 32'hF000_FFFE, "nor");
      run_alu(EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_0003, 32'h0000_0030, "sll");
      run_alu(EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, "srl");
      run_alu(EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, "sra");
      run_alu(EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "addu");
      run_alu(EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "subu");
      run_alu(EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt");
      run_alu(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu");
      run_alu(EXE_OR_OP,   EXE_RES_NOP,   32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "nop");

      run_div(EXE_DIVU_OP, 32'd100,       32'd7,         32'd14,        32'd2,         33, "divu_100_7");
      run_div(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
      run_div(EXE_DIV_OP,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33, "div_7_m2");
      run_div(EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         33, "div_ovf");
      run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'hF,         33, "divu_max");
      run_div(EXE_DIV_OP,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         2,  "div_5_0");

      // Annul in BUSY cycle 10: no HI/LO write may follow.
      @(posedge clk); #1;
      aluop = EXE_DIVU_OP; alusel = EXE_RES_NOP; reg1 = 32'd1000; reg2 = 32'd3; wreg = 1'b0;
      repeat (11) @(negedge clk);
      annul = 1'b1;
      #1;
      check_val("annul_stall", {31'h0, stall_req_o}, 32'h0);
      check_val("annul_whilo", {31'h0, whilo_o}, 32'h0);
      @(posedge clk); #1;
      annul = 1'b0; aluop = EXE_NOP_OP;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (whilo_o === 1'b1 || stall_req_o === 1'b1) seen = 1'b1;
      end
      check_val("annul_no_result", {31'h0, seen}, 32'h0);
      run_div(EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, 33, "divu_9_3");

      // Asynchronous reset in BUSY cycle 5.
      @(posedge clk); #1;
      aluop = EXE_DIVU_OP; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd4; wreg = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_mid_ctrl", {24'h0, wd_o, wreg_o, whilo_o, stall_req_o}, 32'h0);
      check_val("rst_mid_data", wdata_o | hi_o | lo_o, 32'h0);
      aluop = EXE_NOP_OP; wd = 5'd0; wreg = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_release_idle", {31'h0, stall_req_o}, 32'h0);
      run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
